cnn_conv_stream: RTL and testbench



---
 rtl/cnn_pkg.sv | 37 +++
 rtl/cnn_conv_stream_if.sv | 16 +
 rtl/cnn_line_buffer.sv | 40 ++++
 rtl/cnn_conv_stream.sv | 96 +++++++++
 tb/tb_cnn_conv_stream.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared constants and helpers for the streaming 3x3 convolution engine.
//   DATA_RES / WEIGHT_RES : pixel and weight widths (unsigned)
//   IM_DIM                : square image side in pixels
//   ACC_W                 : MAC accumulator width, wide enough for 9 full-scale products
//   LB_DEPTH              : shift-chain depth covering two image rows plus a window row
//   sat_shift()           : normalising right shift with saturation to the pixel range
// -----------------------------------------------------------------------------
package cnn_pkg;

    localparam int DATA_RES     = 8;
    localparam int WEIGHT_RES   = 8;
    localparam int IM_DIM       = 28;
    localparam int KERNEL_WIDTH = 3;
    localparam int KERNEL_SIZE  = KERNEL_WIDTH * KERNEL_WIDTH;
    localparam int OUT_SHIFT    = 4;
    localparam int ACC_W        = DATA_RES + WEIGHT_RES + 4;
    localparam int OUT_W        = DATA_RES;
    localparam int LB_DEPTH     = 2 * IM_DIM + 3;
    localparam int KERNEL_W     = (KERNEL_SIZE + 1) * WEIGHT_RES;

    localparam logic [OUT_W-1:0] OUT_MAX = '1;

    // Shift the accumulator down and clamp anything above the pixel range.
    function automatic logic [OUT_W-1:0] sat_shift(input logic [ACC_W-1:0] acc,
                                                   input int unsigned    shift);
        logic [ACC_W-1:0] res;
        res = acc >> shift;
        if (res > {{(ACC_W-OUT_W){1'b0}}, OUT_MAX}) begin
            return OUT_MAX;
        end else begin
            return res[OUT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/cnn_conv_stream_if.sv
// -----------------------------------------------------------------------------
// cnn_conv_stream_if
// Pixel stream beat: one pixel qualified by a single-cycle valid strobe.
//   pixel      : DATA_RES-bit pixel value
//   data_valid : pixel is transferred this cycle
// Modports: master drives the beat, slave receives it.
// -----------------------------------------------------------------------------
interface cnn_conv_stream_if import cnn_pkg::*; ();

    logic [DATA_RES-1:0] pixel;
    logic                data_valid;

    modport master (output pixel, output data_valid);
    modport slave  (input  pixel, input  data_valid);

endinterface

// File: rtl/cnn_line_buffer.sv
// -----------------------------------------------------------------------------
// cnn_line_buffer
// Shift chain of 2*IM_DIM+3 pixels; the 3x3 window is tapped from it so that
// window element 8 (bottom-right) is always the most recently accepted pixel.
//   clk_i    : clock
//   resetn_i : asynchronous reset, active high
//   en       : shift in pixel this cycle
//   pixel    : incoming pixel
//   window   : 3x3 neighbourhood, index wr*3+wc, 0 = oldest / top-left
// -----------------------------------------------------------------------------
module cnn_line_buffer import cnn_pkg::*; (
    input  logic                                  clk_i,
    input  logic                                  resetn_i,
    input  logic                                  en,
    input  logic [DATA_RES-1:0]                   pixel,
    output logic [KERNEL_SIZE-1:0][DATA_RES-1:0]  window
);

    logic [LB_DEPTH-1:0][DATA_RES-1:0] chain_r;

    // Pixel delay chain; index 0 holds the newest pixel, index IM_DIM one row older.
    always_ff @(posedge clk_i or posedge resetn_i) begin
        if (resetn_i) begin
            chain_r <= '0;
        end else if (en) begin
            chain_r <= {chain_r[LB_DEPTH-2:0], pixel};
        end else begin
            chain_r <= chain_r;
        end
    end

    // Window row wr sits (2-wr) image rows back, column wc sits (2-wc) pixels back.
    for (genvar wr = 0; wr < KERNEL_WIDTH; wr++) begin : g_row
        for (genvar wc = 0; wc < KERNEL_WIDTH; wc++) begin : g_col
            assign window[wr*KERNEL_WIDTH + wc] =
                chain_r[(KERNEL_WIDTH-1-wr)*IM_DIM + (KERNEL_WIDTH-1-wc)];
        end
    end

endmodule

// File: rtl/cnn_conv_stream.sv
// -----------------------------------------------------------------------------
// cnn_conv_stream
// Streaming valid-mode 3x3 convolution over a raster-order IM_DIM x IM_DIM image.
// Result for the window ending at accepted pixel (r,c), r>=2 and c>=2, appears on
// out_if two clocks after the accepting edge; the tail pipeline never stalls.
//   clk_i    : clock
//   resetn_i : asynchronous reset, active high
//   in_if    : input pixel stream (slave)
//   kernel_i : 9 unsigned weights, weight k at [k*8 +: 8]; top byte ignored
//   out_if   : result stream (master), one-cycle valid pulse per result
// -----------------------------------------------------------------------------
module cnn_conv_stream import cnn_pkg::*; (
    input  logic                     clk_i,
    input  logic                     resetn_i,
    cnn_conv_stream_if.slave         in_if,
    input  logic [KERNEL_W-1:0]      kernel_i,
    cnn_conv_stream_if.master        out_if
);

    localparam int               CNT_W    = $clog2(IM_DIM);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IM_DIM - 1);
    localparam logic [CNT_W-1:0] FIRST_OK = CNT_W'(KERNEL_WIDTH - 1);

    logic [CNT_W-1:0]                     col_r;
    logic [CNT_W-1:0]                     row_r;
    logic [KERNEL_SIZE-1:0][DATA_RES-1:0] window_s;
    logic                                 gate_s;
    logic                                 mac_vld_r;
    logic [ACC_W-1:0]                     mac_s;
    logic [ACC_W-1:0]                     acc_r;
    logic                                 acc_vld_r;
    logic [OUT_W-1:0]                     pix_out_r;
    logic                                 vld_out_r;
    logic                                 reserved_unused_s;

    assign reserved_unused_s = ^kernel_i[KERNEL_W-1 -: WEIGHT_RES];

    cnn_line_buffer u_line_buffer (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .en       (in_if.data_valid),
        .pixel    (in_if.pixel),
        .window   (window_s)
    );

    // Raster position of the pixel being accepted this cycle.
    always_ff @(posedge clk_i or posedge resetn_i) begin
        if (resetn_i) begin
            col_r <= '0;
            row_r <= '0;
        end else if (in_if.data_valid) begin
            if (col_r == LAST_IDX) begin
                col_r <= '0;
                row_r <= (row_r == LAST_IDX) ? '0 : row_r + CNT_W'(1);
            end else begin
                col_r <= col_r + CNT_W'(1);
                row_r <= row_r;
            end
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

    // Windows that would straddle a row wrap or frame seam never pass this gate.
    assign gate_s = in_if.data_valid && (row_r >= FIRST_OK) && (col_r >= FIRST_OK);

    // Nine unsigned products summed at full width; cannot overflow ACC_W.
    always_comb begin
        mac_s = '0;
        for (int k = 0; k < KERNEL_SIZE; k++) begin
            mac_s = mac_s + ACC_W'(window_s[k]) * ACC_W'(kernel_i[k*WEIGHT_RES +: WEIGHT_RES]);
        end
    end

    // Two-stage tail: MAC register then saturate register; runs every cycle.
    always_ff @(posedge clk_i or posedge resetn_i) begin
        if (resetn_i) begin
            mac_vld_r <= 1'b0;
            acc_r     <= '0;
            acc_vld_r <= 1'b0;
            pix_out_r <= '0;
            vld_out_r <= 1'b0;
        end else begin
            mac_vld_r <= gate_s;
            acc_vld_r <= mac_vld_r;
            vld_out_r <= acc_vld_r;
            acc_r     <= mac_vld_r ? mac_s : acc_r;
            pix_out_r <= acc_vld_r ? sat_shift(acc_r, OUT_SHIFT) : pix_out_r;
        end
    end

    assign out_if.pixel      = pix_out_r;
    assign out_if.data_valid = vld_out_r;

endmodule

// File: tb/tb_cnn_conv_stream.sv
// -----------------------------------------------------------------------------
// tb_cnn_conv_stream
// Table of whole-frame cases plus hand-written reset and back-to-back sequences.
// Expected results come from an image-array reference model (or closed-form
// values for the constant and ramp images) and are scheduled for the cycle two
// clocks after each accepting edge; every other cycle must show no valid pulse.
// -----------------------------------------------------------------------------
module tb_cnn_conv_stream import cnn_pkg::*; ;

    localparam int EXP_CONST = 0;
    localparam int EXP_RAMP  = 1;
    localparam int EXP_MODEL = 2;
    localparam int PIX_CONST = 0;
    localparam int PIX_RAMP  = 1;
    localparam int PIX_RAND  = 2;
    localparam int N_OUT     = (IM_DIM - 2) * (IM_DIM - 2);

    typedef struct {
        int                  pix_mode;
        int                  pix_val;
        logic [KERNEL_W-1:0] kern;
        int                  gap_pct;
        int                  frames;
        int                  exp_mode;
        int                  exp_val;
    } frame_vec_t;

    typedef struct {
        int due;
        int val;
        int r;
        int c;
    } exp_t;

    logic clk;
    logic resetn_i;
    logic [KERNEL_W-1:0] kernel;

    cnn_conv_stream_if in_if ();
    cnn_conv_stream_if out_if ();

    cnn_conv_stream dut (
        .clk_i    (clk),
        .resetn_i (resetn_i),
        .in_if    (in_if),
        .kernel_i (kernel),
        .out_if   (out_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_mis = 0;
    int   n_out = 0;
    bit   mon_en = 1'b0;
    exp_t exp_q[$];

    int img [IM_DIM][IM_DIM];
    int pr = 0;
    int pc = 0;
    int cur_exp_mode = EXP_MODEL;
    int cur_exp_val  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: each cycle either the scheduled result or silence.
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_if.data_valid === 1'b1) n_out++;
            if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                n_vec++;
                n_mis++;
                $display("FAIL missed_result r=%0d c=%0d due=%0d now=%0d", exp_q[0].r, exp_q[0].c, exp_q[0].due, cyc);
                void'(exp_q.pop_front());
            end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                n_vec++;
                if (out_if.data_valid !== 1'b1 || int'(out_if.pixel) != exp_q[0].val) begin
                    n_mis++;
                    $display("FAIL result r=%0d c=%0d got valid=%b pixel=%0d want valid=1 pixel=%0d",
                             exp_q[0].r, exp_q[0].c, out_if.data_valid, out_if.pixel, exp_q[0].val);
                end
                void'(exp_q.pop_front());
            end else begin
                n_vec++;
                if (out_if.data_valid !== 1'b0) begin
                    n_mis++;
                    $display("FAIL spurious_valid cyc=%0d got valid=%b want 0", cyc, out_if.data_valid);
                end
            end
        end
    end

    function automatic int gaussian_dummy();
        return 0;
    endfunction

    // Reference result for the window whose bottom-right pixel is (r,c).
    function automatic int expect_val(int r, int c);
        int acc;
        logic [WEIGHT_RES-1:0] w;
        acc = 0;
        case (cur_exp_mode)
            EXP_CONST: return cur_exp_val;
            EXP_RAMP:  return c - 1;
            default: begin
                for (int wr = 0; wr < 3; wr++) begin
                    for (int wc = 0; wc < 3; wc++) begin
                        w = kernel[(wr*3 + wc)*WEIGHT_RES +: WEIGHT_RES];
                        acc += img[r-2+wr][c-2+wc] * int'(w);
                    end
                end
                acc = acc / (1 << OUT_SHIFT);
                return (acc > 255) ? 255 : acc;
            end
        endcase
    endfunction

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_mis++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic idle(input int n);
        in_if.data_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Accept one pixel (after optional random idle gaps) and schedule its result.
    task automatic send_pix(input int p, input int gap_pct);
        exp_t ev;
        int   gaps;
        gaps = 0;
        while (gaps < 3 && int'($urandom_range(99)) < gap_pct) begin
            in_if.data_valid = 1'b0;
            @(posedge clk);
            #1;
            gaps++;
        end
        img[pr][pc] = p;
        in_if.pixel = DATA_RES'(p);
        in_if.data_valid = 1'b1;
        @(posedge clk);
        #1;
        in_if.data_valid = 1'b0;
        if (pr >= 2 && pc >= 2) begin
            ev.due = cyc + 2;
            ev.val = expect_val(pr, pc);
            ev.r   = pr;
            ev.c   = pc;
            exp_q.push_back(ev);
        end
        if (pc == IM_DIM - 1) begin
            pc = 0;
            pr = (pr == IM_DIM - 1) ? 0 : pr + 1;
        end else begin
            pc = pc + 1;
        end
    endtask

    function automatic int pick_pix(int mode, int val, int c);
        case (mode)
            PIX_CONST: return val;
            PIX_RAMP:  return c;
            default:   return int'($urandom_range(255));
        endcase
    endfunction

    task automatic pulse_reset();
        resetn_i = 1'b1;
        in_if.data_valid = 1'b0;
        exp_q.delete();
        #1;
        check("reset_pixel", int'(out_if.pixel), 0);
        check("reset_valid", int'(out_if.data_valid), 0);
        @(posedge clk);
        #1;
        resetn_i = 1'b0;
        pr = 0;
        pc = 0;
    endtask

    frame_vec_t vecs[8];
    logic [KERNEL_W-1:0] gauss;
    logic [KERNEL_W-1:0] ones;
    logic [KERNEL_W-1:0] all_ff;
    logic [KERNEL_W-1:0] rnd_k;

    initial begin
        gauss  = {8'h00, 8'h01, 8'h02, 8'h01, 8'h02, 8'h04, 8'h02, 8'h01, 8'h02, 8'h01};
        ones   = {8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
        all_ff = {8'h00, {72{1'b1}}};
        rnd_k  = KERNEL_W'({$urandom, $urandom, $urandom});

        vecs[0] = '{PIX_CONST, 1,   gauss,                    0,  1, EXP_CONST, 1};
        vecs[1] = '{PIX_RAMP,  0,   gauss,                    0,  1, EXP_RAMP,  0};
        vecs[2] = '{PIX_CONST, 255, all_ff,                   0,  1, EXP_CONST, 255};
        vecs[3] = '{PIX_RAMP,  0,   gauss,                    40, 1, EXP_RAMP,  0};
        vecs[4] = '{PIX_RAMP,  0,   gauss,                    0,  2, EXP_RAMP,  0};
        vecs[5] = '{PIX_CONST, 16,  ones,                     0,  1, EXP_CONST, 9};
        vecs[6] = '{PIX_CONST, 1,   {8'hA5, gauss[71:0]},     0,  1, EXP_CONST, 1};
        vecs[7] = '{PIX_RAND,  0,   rnd_k,                    30, 2, EXP_MODEL, 0};

        resetn_i = 1'b1;
        in_if.pixel = '0;
        in_if.data_valid = 1'b0;
        kernel = gauss;
        repeat (3) @(posedge clk);
        #1;
        check("init_pixel", int'(out_if.pixel), 0);
        check("init_valid", int'(out_if.data_valid), 0);
        resetn_i = 1'b0;
        mon_en = 1'b1;

        // Whole-frame table cases.
        for (int v = 0; v < 8; v++) begin
            kernel = vecs[v].kern;
            cur_exp_mode = vecs[v].exp_mode;
            cur_exp_val  = vecs[v].exp_val;
            idle(2);
            n_out = 0;
            for (int f = 0; f < vecs[v].frames; f++) begin
                for (int i = 0; i < IM_DIM * IM_DIM; i++) begin
                    send_pix(pick_pix(vecs[v].pix_mode, vecs[v].pix_val, pc), vecs[v].gap_pct);
                end
            end
            idle(4);
            check($sformatf("case%0d_out_count", v), n_out, N_OUT * vecs[v].frames);
            check($sformatf("case%0d_queue_drained", v), exp_q.size(), 0);
        end

        // Reset mid-frame, then a full frame restarting at (0,0).
        kernel = gauss;
        cur_exp_mode = EXP_RAMP;
        for (int i = 0; i < 400; i++) send_pix(pc, 0);
        pulse_reset();
        n_out = 0;
        idle(3);
        check("post_reset_quiet", n_out, 0);
        for (int i = 0; i < IM_DIM * IM_DIM; i++) send_pix(pc, 0);
        idle(4);
        check("post_reset_out_count", n_out, N_OUT);
        check("post_reset_queue_drained", exp_q.size(), 0);

        // Kernel update between frames with random pixels.
        kernel = KERNEL_W'({$urandom, $urandom, $urandom});
        cur_exp_mode = EXP_MODEL;
        idle(3);
        n_out = 0;
        for (int i = 0; i < IM_DIM * IM_DIM; i++) send_pix(int'($urandom_range(255)), 10);
        idle(4);
        check("rand_kernel_out_count", n_out, N_OUT);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
